smc_wr_strobe_ctrl: RTL and testbench

SMC_WR_STROBE_CTRL -- requirements
Module: smc_wr_strobe_ctrl

---
 rtl/smc_pkg.sv | 25 ++
 rtl/smc_wait_cnt.sv | 29 ++
 rtl/smc_wr_strobe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_smc_wr_strobe_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// Shared types and constants for the SMC write-strobe controller.
// Optional TURN phase is enabled by defining SMC_WR_TURNAROUND_EN.
package smc_pkg;

  localparam int SMC_CNT_W = 4;
  localparam int SMC_BE_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
`ifdef SMC_WR_TURNAROUND_EN
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
`else
    ST_HOLD   = 3'd3
`endif
  } smc_state_e;

  // Levels driven on the bus-facing outputs whenever no strobe is active.
  localparam logic WR_ACK_OFF = 1'b0;
  localparam logic R_FULL_OFF = 1'b0;
  localparam logic N_R_WR_OFF = 1'b1;

endpackage

// File: rtl/smc_wait_cnt.sv
// Phase timer: loadable down-counter that saturates at zero.
module smc_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/smc_wr_strobe_ctrl.sv
// Static-memory write strobe sequencer: SETUP -> STROBE -> HOLD (-> TURN) -> ack.
// Define SMC_WR_TURNAROUND_EN to add the cfg_wt port and TURN phase.
module smc_wr_strobe_ctrl
  import smc_pkg::*;
#(
  parameter int CNT_W = SMC_CNT_W,
  parameter int BE_W  = SMC_BE_W
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             wr_req,
  input  logic [BE_W-1:0]  wr_be,
  input  logic [CNT_W-1:0] cfg_ws,
  input  logic [CNT_W-1:0] cfg_we,
  input  logic [CNT_W-1:0] cfg_wh,
`ifdef SMC_WR_TURNAROUND_EN
  input  logic [CNT_W-1:0] cfg_wt,
`endif
  output logic             wr_ack,
  output logic             busy,
  output logic             r_full,
  output logic [BE_W-1:0]  n_r_we,
  output logic             n_r_wr
);

  smc_state_e       state_q, state_d;
  logic [BE_W-1:0]  be_q, be_d;
  logic [CNT_W-1:0] we_q, we_d;
  logic [CNT_W-1:0] wh_q, wh_d;
`ifdef SMC_WR_TURNAROUND_EN
  logic [CNT_W-1:0] wt_q, wt_d;
`endif

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  smc_state_e       post_state;
  logic [CNT_W-1:0] post_val;

  logic             wr_ack_q, wr_ack_d;
  logic             busy_q, busy_d;
  logic             r_full_q, r_full_d;
  logic [BE_W-1:0]  n_r_we_q, n_r_we_d;
  logic             n_r_wr_q, n_r_wr_d;

  // The setup count is captured directly into the counter at acceptance.
  smc_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    state_d    = state_q;
    be_d       = be_q;
    we_d       = we_q;
    wh_d       = wh_q;
`ifdef SMC_WR_TURNAROUND_EN
    wt_d       = wt_q;
    post_state = (wt_q != '0) ? ST_TURN : ST_IDLE;
    post_val   = wt_q - CNT_W'(1);
`else
    post_state = ST_IDLE;
    post_val   = '0;
`endif
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_req && !wr_ack_q) begin
          be_d     = wr_be;
          we_d     = cfg_we;
          wh_d     = cfg_wh;
`ifdef SMC_WR_TURNAROUND_EN
          wt_d     = cfg_wt;
`endif
          cnt_load = 1'b1;
          if (cfg_ws != '0) begin
            state_d = ST_SETUP;
            cnt_val = cfg_ws - CNT_W'(1);
          end else begin
            state_d = ST_STROBE;
            cnt_val = cfg_we;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d  = ST_STROBE;
          cnt_load = 1'b1;
          cnt_val  = we_q;
        end else cnt_dec = 1'b1;
      end
      ST_STROBE: begin
        if (!cnt_zero)         cnt_dec = 1'b1;
        else if (wh_q != '0) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = wh_q - CNT_W'(1);
        end else begin
          state_d  = post_state;
          cnt_load = (post_state != ST_IDLE);
          cnt_val  = post_val;
        end
      end
      ST_HOLD: begin
        if (!cnt_zero) cnt_dec = 1'b1;
        else begin
          state_d  = post_state;
          cnt_load = (post_state != ST_IDLE);
          cnt_val  = post_val;
        end
      end
`ifdef SMC_WR_TURNAROUND_EN
      ST_TURN: begin
        if (cnt_zero) state_d = ST_IDLE;
        else          cnt_dec = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the phase itself.
    wr_ack_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    r_full_d = (state_d == ST_STROBE);
    n_r_wr_d = (state_d == ST_STROBE) ? 1'b0 : N_R_WR_OFF;
    n_r_we_d = (state_d == ST_STROBE) ? ~be_d : '1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q  <= ST_IDLE;
      be_q     <= '0;
      we_q     <= '0;
      wh_q     <= '0;
`ifdef SMC_WR_TURNAROUND_EN
      wt_q     <= '0;
`endif
      wr_ack_q <= WR_ACK_OFF;
      busy_q   <= 1'b0;
      r_full_q <= R_FULL_OFF;
      n_r_wr_q <= N_R_WR_OFF;
      n_r_we_q <= '1;
    end else begin
      state_q  <= state_d;
      be_q     <= be_d;
      we_q     <= we_d;
      wh_q     <= wh_d;
`ifdef SMC_WR_TURNAROUND_EN
      wt_q     <= wt_d;
`endif
      wr_ack_q <= wr_ack_d;
      busy_q   <= busy_d;
      r_full_q <= r_full_d;
      n_r_wr_q <= n_r_wr_d;
      n_r_we_q <= n_r_we_d;
    end
  end

  assign wr_ack = wr_ack_q;
  assign busy   = busy_q;
  assign r_full = r_full_q;
  assign n_r_we = n_r_we_q;
  assign n_r_wr = n_r_wr_q;

endmodule

// File: tb/tb_smc_wr_strobe_ctrl.sv
// Self-checking bench for smc_wr_strobe_ctrl; the model expands each accepted
// access into its expected per-cycle output timeline.
module tb_smc_wr_strobe_ctrl;

`ifdef SMC_WR_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  typedef struct packed {
    logic       ack;
    logic       busy;
    logic       r_full;
    logic       n_wr;
    logic [3:0] n_we;
  } out_t;

  localparam out_t IDLE_O = '{ack: 1'b0, busy: 1'b0, r_full: 1'b0, n_wr: 1'b1, n_we: 4'hF};

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic       wr_req;
  logic [3:0] wr_be;
  logic [3:0] cfg_ws, cfg_we, cfg_wh, cfg_wt;
  logic       wr_ack, busy, r_full, n_r_wr;
  logic [3:0] n_r_we;

  int   n_cmp  = 0;
  int   n_fail = 0;
  out_t exp_q[$];
  out_t exp_cur = IDLE_O;

  always #5 sys_clk = ~sys_clk;

  smc_wr_strobe_ctrl #(.CNT_W(4), .BE_W(4)) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .wr_req   (wr_req),
    .wr_be    (wr_be),
    .cfg_ws   (cfg_ws),
    .cfg_we   (cfg_we),
    .cfg_wh   (cfg_wh),
`ifdef SMC_WR_TURNAROUND_EN
    .cfg_wt   (cfg_wt),
`endif
    .wr_ack   (wr_ack),
    .busy     (busy),
    .r_full   (r_full),
    .n_r_we   (n_r_we),
    .n_r_wr   (n_r_wr)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // Expected timeline of one access: ws setup, we+1 strobe, wh hold, wt turn, then ack.
  task automatic build(input int ws, input int we, input int wh, input int wt, input logic [3:0] be);
    out_t o;
    o = '{ack: 1'b0, busy: 1'b1, r_full: 1'b0, n_wr: 1'b1, n_we: 4'hF};
    for (int i = 0; i < ws; i++) exp_q.push_back(o);
    for (int i = 0; i <= we; i++)
      exp_q.push_back('{ack: 1'b0, busy: 1'b1, r_full: 1'b1, n_wr: 1'b0, n_we: ~be});
    for (int i = 0; i < wh + wt; i++) exp_q.push_back(o);
    exp_q.push_back('{ack: 1'b1, busy: 1'b0, r_full: 1'b0, n_wr: 1'b1, n_we: 4'hF});
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    if (sys_reset) begin
      exp_q.delete();
      exp_cur = IDLE_O;
    end else if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
    end else if (wr_req && !exp_cur.ack) begin
      build(int'(cfg_ws), int'(cfg_we), int'(cfg_wh), TURN_EN ? int'(cfg_wt) : 0, wr_be);
      exp_cur = exp_q.pop_front();
    end else begin
      exp_cur = IDLE_O;
    end
    #1;
    check({tag, ".wr_ack"}, {7'd0, wr_ack}, {7'd0, exp_cur.ack});
    check({tag, ".busy"},   {7'd0, busy},   {7'd0, exp_cur.busy});
    check({tag, ".r_full"}, {7'd0, r_full}, {7'd0, exp_cur.r_full});
    check({tag, ".n_r_wr"}, {7'd0, n_r_wr}, {7'd0, exp_cur.n_wr});
    check({tag, ".n_r_we"}, {4'd0, n_r_we}, {4'd0, exp_cur.n_we});
  endtask

  // One protocol-conforming access; measures accept-to-ack latency with a bounded wait.
  task automatic run_access(input string tag, input logic [3:0] ws, input logic [3:0] we,
                            input logic [3:0] wh, input logic [3:0] wt, input logic [3:0] be,
                            input int exp_lat);
    int lat;
    wr_req = 1'b0;
    step({tag, ".pre"});
    cfg_ws = ws; cfg_we = we; cfg_wh = wh; cfg_wt = wt; wr_be = be;
    wr_req = 1'b1;
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      step(tag);
      lat++;
      if (wr_ack) break;
    end
    wr_req = 1'b0;
    check({tag, ".latency"}, 8'(lat), 8'(exp_lat));
  endtask

  initial begin
    sys_reset = 1'b1; wr_req = 1'b1; wr_be = 4'hF;
    cfg_ws = 4'd0; cfg_we = 4'd0; cfg_wh = 4'd0; cfg_wt = 4'd0;

    // Reset holds the block idle even with a pending request.
    step("reset0");
    step("reset1");
    sys_reset = 1'b0;
    step("post_reset_accept");
    for (int i = 0; i < 3; i++) step("post_reset_run");
    wr_req = 1'b0;
    step("idle");

    run_access("basic_ws2", 4'd2, 4'd1, 4'd1, 4'd0, 4'b0101, 6);
    run_access("zero_all",  4'd0, 4'd0, 4'd0, 4'd0, 4'hF, 2);
    run_access("no_lanes",  4'd1, 4'd2, 4'd2, 4'd0, 4'h0, 7);
    run_access("max_we",    4'd0, 4'd15, 4'd0, 4'd0, 4'b1001, 17);
    run_access("turn_wt3",  4'd0, 4'd0, 4'd0, 4'd3, 4'hF, TURN_EN ? 5 : 2);
    run_access("turn_mix",  4'd1, 4'd0, 4'd2, 4'd2, 4'b0110, TURN_EN ? 7 : 5);

    // Back-to-back requests: one ack cycle separates accesses.
    cfg_ws = 4'd1; cfg_we = 4'd1; cfg_wh = 4'd1; cfg_wt = 4'd0; wr_be = 4'b1100;
    wr_req = 1'b1;
    for (int i = 0; i < 20; i++) step("b2b");
    wr_req = 1'b0;
    for (int i = 0; i < 8; i++) step("b2b_drain");

    // Config change during SETUP must not stretch or shrink the strobe.
    cfg_ws = 4'd2; cfg_we = 4'd3; cfg_wh = 4'd0; wr_be = 4'b0011;
    wr_req = 1'b1;
    step("cfg_chg_accept");
    cfg_we = 4'd0; cfg_ws = 4'd0; cfg_wh = 4'd5; wr_be = 4'hF;
    wr_req = 1'b0;
    for (int i = 0; i < 8; i++) step("cfg_chg");

    // Reset during STROBE aborts without an ack.
    cfg_ws = 4'd1; cfg_we = 4'd3; cfg_wh = 4'd1; wr_be = 4'b1010;
    wr_req = 1'b1;
    for (int i = 0; i < 3; i++) step("abort_run");
    check("abort_in_strobe", {7'd0, exp_cur.r_full}, 8'd1);
    wr_req = 1'b0;
    sys_reset = 1'b1;
    step("abort_reset");
    sys_reset = 1'b0;
    for (int i = 0; i < 6; i++) step("abort_after");

    // Randomised traffic, including mid-access request drops, config churn and resets.
    for (int i = 0; i < 600; i++) begin
      sys_reset = ($urandom_range(0, 79) == 0);
      wr_req    = ($urandom_range(0, 3) != 0);
      wr_be     = 4'($urandom);
      cfg_ws    = 4'($urandom_range(0, 3));
      cfg_we    = 4'($urandom_range(0, 3));
      cfg_wh    = 4'($urandom_range(0, 3));
      cfg_wt    = 4'($urandom_range(0, 3));
      step("random");
    end
    sys_reset = 1'b0;
    wr_req = 1'b0;
    for (int i = 0; i < 20; i++) step("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
